// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: filtered IR line follower with follow/search/stop FSM and PWM wheel drive
module line_follow_ctrl #(
  parameter int NUM_SENSORS  = 5,
  parameter int SAMPLE_DIV   = 100000,
  parameter int FILT_LEN     = 4,
  parameter int PWM_BITS     = 10,
  parameter int DUTY_FULL    = 1000,
  parameter int DUTY_TURN    = 500,
  parameter int DUTY_SEARCH  = 600,
  parameter int LOST_TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_n,
  input  logic                   obstacle,
  output logic [NUM_SENSORS-1:0] line_vec,
  output logic [2:0]             fsm_state,
  output logic [1:0]             left_dir,
  output logic [1:0]             right_dir,
  output logic                   left_pwm,
  output logic                   right_pwm
);
  typedef enum logic [2:0] {IDLE = 3'd0, FOLLOW = 3'd1, SEARCH = 3'd2, STOP_OBS = 3'd3, LOST = 3'd4} state_t;
  localparam int DVW = $clog2(SAMPLE_DIV);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int SW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [1:0] FWD = 2'b10, REV = 2'b01, STP = 2'b00;
  state_t state_q, state_d;
  logic [DVW-1:0] div_q, div_d;
  logic tick, stop, pivot;
  logic [NUM_SENSORS-1:0] line_q, line_d;
  logic [FW-1:0] filt_q [NUM_SENSORS];
  logic [FW-1:0] filt_d [NUM_SENSORS];
  logic obs_s1_q, obs_s2_q;
  logic last_right_q, last_right_d;
  logic [SW-1:0] search_q, search_d;
  logic [1:0] ldir_q, ldir_d, rdir_q, rdir_d;
  logic [31:0] lduty_q, lduty_d, rduty_q, rduty_d, llat_q, llat_d, rlat_q, rlat_d;
  logic [PWM_BITS-1:0] pcnt_q;
  logic lpwm_q, lpwm_d, rpwm_q, rpwm_d;
  int hi, lo, err, aerr;
  assign tick = div_q == DVW'(SAMPLE_DIV - 1);
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign stop = !(state_q == FOLLOW || state_q == SEARCH);
  always_comb begin
    line_d = line_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      filt_d[i] = filt_q[i];
      if (tick && (~sensor_n[i] != line_q[i])) begin
        filt_d[i] = (filt_q[i] == FW'(FILT_LEN - 1)) ? '0 : filt_q[i] + 1'b1;
        line_d[i] = (filt_q[i] == FW'(FILT_LEN - 1)) ? ~sensor_n[i] : line_q[i];
      end else if (tick) filt_d[i] = '0;
    end
  end
  always_comb begin
    hi = 0;
    lo = 0;
    for (int i = 0; i < NUM_SENSORS; i++) if (line_q[i]) hi = i;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) if (line_q[i]) lo = i;
    err = (line_q == '0) ? 0 : hi + lo - (NUM_SENSORS - 1);
    aerr = err < 0 ? -err : err;
  end
  always_comb begin
    state_d = state_q;
    last_right_d = last_right_q;
    search_d = search_q;
    if (!enable) state_d = IDLE;
    else if (obs_s2_q && !stop) state_d = STOP_OBS;
    else
      case (state_q)
        IDLE: state_d = FOLLOW;
        FOLLOW:
          if (line_q == '0) begin
            state_d = SEARCH;
            search_d = '0;
          end else if (err != 0) last_right_d = err < 0;
        SEARCH:
          if (line_q != '0) state_d = FOLLOW;
          else if (tick) begin
            search_d = search_q + 1'b1;
            if (search_d == SW'(LOST_TIMEOUT)) state_d = LOST;
          end
        STOP_OBS: if (!obs_s2_q) state_d = FOLLOW;
        default: ;
      endcase
  end
  // Duties latch only at the PWM period start; stop bypasses the latch and kills pwm at once.
  always_comb begin
    pivot = aerr >= NUM_SENSORS - 1;
    ldir_d = STP;
    rdir_d = STP;
    lduty_d = '0;
    rduty_d = '0;
    if (state_q == FOLLOW) begin
      ldir_d = (err > 0 && pivot) ? REV : FWD;
      rdir_d = (err < 0 && pivot) ? REV : FWD;
      lduty_d = 32'(err > 0 ? DUTY_TURN : DUTY_FULL);
      rduty_d = 32'(err < 0 ? DUTY_TURN : DUTY_FULL);
    end else if (state_q == SEARCH) begin
      ldir_d = last_right_q ? FWD : REV;
      rdir_d = last_right_q ? REV : FWD;
      lduty_d = 32'(DUTY_SEARCH);
      rduty_d = 32'(DUTY_SEARCH);
    end
    llat_d = (pcnt_q == '0) ? lduty_q : llat_q;
    rlat_d = (pcnt_q == '0) ? rduty_q : rlat_q;
    lpwm_d = !stop && (32'(pcnt_q) < llat_d);
    rpwm_d = !stop && (32'(pcnt_q) < rlat_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      line_q <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) filt_q[i] <= '0;
      obs_s1_q <= 1'b0;
      obs_s2_q <= 1'b0;
      last_right_q <= 1'b0;
      search_q <= '0;
      ldir_q <= STP;
      rdir_q <= STP;
      lduty_q <= '0;
      rduty_q <= '0;
      llat_q <= '0;
      rlat_q <= '0;
      pcnt_q <= '0;
      lpwm_q <= 1'b0;
      rpwm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      line_q <= line_d;
      for (int i = 0; i < NUM_SENSORS; i++) filt_q[i] <= filt_d[i];
      obs_s1_q <= obstacle;
      obs_s2_q <= obs_s1_q;
      last_right_q <= last_right_d;
      search_q <= search_d;
      ldir_q <= ldir_d;
      rdir_q <= rdir_d;
      lduty_q <= lduty_d;
      rduty_q <= rduty_d;
      llat_q <= llat_d;
      rlat_q <= rlat_d;
      pcnt_q <= pcnt_q + 1'b1;
      lpwm_q <= lpwm_d;
      rpwm_q <= rpwm_d;
    end
  end
  assign line_vec = line_q;
  assign fsm_state = state_q;
  assign left_dir = ldir_q;
  assign right_dir = rdir_q;
  assign left_pwm = lpwm_q;
  assign right_pwm = rpwm_q;
endmodule
